// File: rtl/microseq_pkg.sv
// Shared encodings for the micro-BESM sequencer: SQI instruction codes and
// the active-low source-enable pattern driven onto {pl_n, map_n, vect_n}.
package microseq_pkg;

  typedef enum logic [3:0] {
    JZ   = 4'd0,
    CJS  = 4'd1,
    JMAP = 4'd2,
    CJP  = 4'd3,
    PUSH = 4'd4,
    JSRP = 4'd5,
    CJV  = 4'd6,
    JRP  = 4'd7,
    RFCT = 4'd8,
    RPCT = 4'd9,
    CRTN = 4'd10,
    CJPP = 4'd11,
    LDCT = 4'd12,
    LOOP = 4'd13,
    CONT = 4'd14,
    TWB  = 4'd15
  } sqi_t;

  // Bit order is {pl_n, map_n, vect_n}; exactly one bit is low.
  typedef enum logic [2:0] {
    EN_PL   = 3'b011,
    EN_MAP  = 3'b101,
    EN_VECT = 3'b110
  } src_en_t;

endpackage

// File: rtl/microseq_seq_stack.sv
// Subroutine/loop stack for microseq: DEPTH x W entries plus stack pointer,
// saturating on push-when-full and pop-when-empty.
module seq_stack
  import microseq_pkg::*;
#(
  parameter int unsigned W     = 12,
  parameter int unsigned DEPTH = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full
);

  localparam int unsigned SPW = $clog2(DEPTH + 1);
  localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
  localparam logic [IW-1:0]  TOP_IDX = IW'(DEPTH - 1);

  logic [W-1:0]   mem_q [DEPTH];
  logic [W-1:0]   mem_d [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic           full_q;

  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    if (clear) begin
      sp_d = '0;
    end else if (push) begin
      // A push at full replaces the top entry instead of growing the stack.
      if (sp_q == SP_FULL) begin
        mem_d[TOP_IDX] = din;
      end else begin
        mem_d[IW'(sp_q)] = din;
        sp_d             = sp_q + SPW'(1);
      end
    end else if (pop) begin
      if (sp_q != '0) sp_d = sp_q - SPW'(1);
    end
  end

  // Empty stack exposes entry 0, i.e. the last value written there.
  assign top  = (sp_q == '0) ? mem_q[0] : mem_q[IW'(sp_q - SPW'(1))];
  assign full = full_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      sp_q   <= '0;
      full_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      sp_q   <= sp_d;
      full_q <= (sp_d == SP_FULL);
    end
  end

endmodule

// File: rtl/microseq.sv
// Am2910-style microprogram sequencer: decodes SQI, selects the next
// micro-address y and maintains microPC, the R register/counter and the stack.
module microseq
  import microseq_pkg::*;
#(
  parameter int unsigned W     = 12,
  parameter int unsigned DEPTH = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [3:0]   sqi,
  input  logic [W-1:0] d,
  input  logic         cc_n,
  input  logic         ccen_n,
  input  logic         rld_n,
  input  logic         ci,
  output logic [W-1:0] y,
  output logic         full_n,
  output logic         pl_n,
  output logic         map_n,
  output logic         vect_n
);

  logic [W-1:0] upc_q, upc_d;
  logic [W-1:0] r_q, r_d;
  logic [W-1:0] top;
  logic         full;
  logic         pass, rz;
  logic         push, pop, clear, r_load, r_dec;
  src_en_t      en;

  assign pass = ccen_n | ~cc_n;
  assign rz   = (r_q == '0);

  always_comb begin
    y      = upc_q;
    push   = 1'b0;
    pop    = 1'b0;
    clear  = 1'b0;
    r_load = 1'b0;
    r_dec  = 1'b0;
    en     = EN_PL;
    case (sqi_t'(sqi))
      JZ:   begin y = '0; clear = 1'b1; end
      CJS:  if (pass) begin y = d; push = 1'b1; end
      JMAP: begin y = d; en = EN_MAP; end
      CJP:  if (pass) y = d;
      PUSH: begin push = 1'b1; r_load = pass; end
      JSRP: begin push = 1'b1; y = pass ? d : r_q; end
      CJV:  begin en = EN_VECT; if (pass) y = d; end
      JRP:  y = pass ? d : r_q;
      RFCT: if (!rz) begin y = top; r_dec = 1'b1; end else pop = 1'b1;
      RPCT: if (!rz) begin y = d; r_dec = 1'b1; end
      CRTN: if (pass) begin y = top; pop = 1'b1; end
      CJPP: if (pass) begin y = d; pop = 1'b1; end
      LDCT: r_load = 1'b1;
      LOOP: if (pass) pop = 1'b1; else y = top;
      CONT: ;
      TWB: begin
        // Counter expired: always pop; a failing condition exits to d.
        if (!rz) begin
          if (!pass) begin y = top; r_dec = 1'b1; end
          else pop = 1'b1;
        end else begin
          pop = 1'b1;
          if (!pass) y = d;
        end
      end
      default: ;
    endcase
  end

  assign {pl_n, map_n, vect_n} = en;
  assign full_n = ~full;

  always_comb begin
    upc_d = y + {{(W-1){1'b0}}, ci};
    if (!rld_n)      r_d = d;
    else if (r_load) r_d = d;
    else if (r_dec)  r_d = r_q - {{(W-1){1'b0}}, 1'b1};
    else             r_d = r_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upc_q <= '0;
      r_q   <= '0;
    end else begin
      upc_q <= upc_d;
      r_q   <= r_d;
    end
  end

  seq_stack #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .clear   (clear),
    .din     (upc_q),
    .top     (top),
    .full    (full)
  );

endmodule
